// File: rtl/pass_scheduler.sv
// Layer sequencer: walks m (outer), h, c (inner) tiles, issuing one Controller_pass run per tile
// with registered GLB base addresses built from running offsets.
module pass_scheduler #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              layer_start,
    input  logic              layer_abort,
    input  logic [CNT_W-1:0]  num_m,
    input  logic [CNT_W-1:0]  num_h,
    input  logic [CNT_W-1:0]  num_c,
    input  logic [ADDR_W-1:0] filter_base,
    input  logic [ADDR_W-1:0] ifmap_base,
    input  logic [ADDR_W-1:0] bias_base,
    input  logic [ADDR_W-1:0] opsum_base,
    input  logic [ADDR_W-1:0] filter_m_stride,
    input  logic [ADDR_W-1:0] filter_c_stride,
    input  logic [ADDR_W-1:0] ifmap_h_stride,
    input  logic [ADDR_W-1:0] ifmap_c_stride,
    input  logic [ADDR_W-1:0] bias_m_stride,
    input  logic [ADDR_W-1:0] opsum_m_stride,
    input  logic [ADDR_W-1:0] opsum_h_stride,
    output logic              pass_start,
    input  logic              pass_done,
    output logic              bias_ipsum_sel,
    output logic [ADDR_W-1:0] pass_filter_baseaddr,
    output logic [ADDR_W-1:0] pass_ifmap_baseaddr,
    output logic [ADDR_W-1:0] pass_bias_baseaddr,
    output logic [ADDR_W-1:0] pass_opsum_baseaddr,
    output logic [CNT_W-1:0]  m_idx,
    output logic [CNT_W-1:0]  h_idx,
    output logic [CNT_W-1:0]  c_idx,
    output logic              busy,
    output logic              layer_done
);
    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, ADVANCE, DONE} state_t;

    typedef struct packed {
        logic [CNT_W-1:0]  n_m, n_h, n_c;
        logic [ADDR_W-1:0] f_base, i_base, b_base, o_base;
        logic [ADDR_W-1:0] f_m_str, f_c_str, i_h_str, i_c_str, b_m_str, o_m_str, o_h_str;
    } cfg_t;

    state_t state, state_nxt;
    cfg_t   cfg;

    // Running offsets, one per (address, loop) term; each equals index * stride.
    logic [ADDR_W-1:0] f_m_off, f_c_off, i_h_off, i_c_off, b_m_off, o_m_off, o_h_off;
    logic [ADDR_W-1:0] f_m_nxt, f_c_nxt, i_h_nxt, i_c_nxt, b_m_nxt, o_m_nxt, o_h_nxt;
    logic [CNT_W-1:0]  m_nxt, h_nxt, c_nxt;
    logic              c_last, h_last, m_last, any_zero;

    assign c_last   = (c_idx == cfg.n_c - CNT_W'(1));
    assign h_last   = (h_idx == cfg.n_h - CNT_W'(1));
    assign m_last   = (m_idx == cfg.n_m - CNT_W'(1));
    assign any_zero = (num_m == '0) || (num_h == '0) || (num_c == '0);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (layer_start) state_nxt = any_zero ? DONE : LAUNCH;
            LAUNCH:  state_nxt = WAIT;
            WAIT:    if (pass_done) state_nxt = ADVANCE;
            ADVANCE: state_nxt = (m_last && h_last && c_last) ? DONE : LAUNCH;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (layer_abort && state != IDLE) state_nxt = IDLE;
    end

    always_comb begin
        c_nxt   = c_last ? '0 : c_idx + CNT_W'(1);
        f_c_nxt = c_last ? '0 : f_c_off + cfg.f_c_str;
        i_c_nxt = c_last ? '0 : i_c_off + cfg.i_c_str;
        h_nxt   = h_idx;
        i_h_nxt = i_h_off;
        o_h_nxt = o_h_off;
        m_nxt   = m_idx;
        f_m_nxt = f_m_off;
        b_m_nxt = b_m_off;
        o_m_nxt = o_m_off;
        if (c_last) begin
            h_nxt   = h_last ? '0 : h_idx + CNT_W'(1);
            i_h_nxt = h_last ? '0 : i_h_off + cfg.i_h_str;
            o_h_nxt = h_last ? '0 : o_h_off + cfg.o_h_str;
            if (h_last) begin
                m_nxt   = m_idx + CNT_W'(1);
                f_m_nxt = f_m_off + cfg.f_m_str;
                b_m_nxt = b_m_off + cfg.b_m_str;
                o_m_nxt = o_m_off + cfg.o_m_str;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Any return to IDLE (done, abort) clears the datapath so idle outputs read as zero.
    always_ff @(posedge clk) begin
        if (rst || (state != IDLE && state_nxt == IDLE)) begin
            cfg <= '0;
            {m_idx, h_idx, c_idx} <= '0;
            {f_m_off, f_c_off, i_h_off, i_c_off, b_m_off, o_m_off, o_h_off} <= '0;
            pass_filter_baseaddr <= '0;
            pass_ifmap_baseaddr  <= '0;
            pass_bias_baseaddr   <= '0;
            pass_opsum_baseaddr  <= '0;
            bias_ipsum_sel       <= 1'b0;
        end else if (state == IDLE && layer_start) begin
            cfg <= '{num_m, num_h, num_c, filter_base, ifmap_base, bias_base, opsum_base,
                     filter_m_stride, filter_c_stride, ifmap_h_stride, ifmap_c_stride,
                     bias_m_stride, opsum_m_stride, opsum_h_stride};
            {m_idx, h_idx, c_idx} <= '0;
            {f_m_off, f_c_off, i_h_off, i_c_off, b_m_off, o_m_off, o_h_off} <= '0;
            pass_filter_baseaddr <= filter_base;
            pass_ifmap_baseaddr  <= ifmap_base;
            pass_bias_baseaddr   <= bias_base;
            pass_opsum_baseaddr  <= opsum_base;
            bias_ipsum_sel       <= 1'b1;
        end else if (state == ADVANCE && state_nxt == LAUNCH) begin
            m_idx   <= m_nxt;
            h_idx   <= h_nxt;
            c_idx   <= c_nxt;
            f_m_off <= f_m_nxt;
            f_c_off <= f_c_nxt;
            i_h_off <= i_h_nxt;
            i_c_off <= i_c_nxt;
            b_m_off <= b_m_nxt;
            o_m_off <= o_m_nxt;
            o_h_off <= o_h_nxt;
            pass_filter_baseaddr <= cfg.f_base + f_m_nxt + f_c_nxt;
            pass_ifmap_baseaddr  <= cfg.i_base + i_h_nxt + i_c_nxt;
            pass_bias_baseaddr   <= cfg.b_base + b_m_nxt;
            pass_opsum_baseaddr  <= cfg.o_base + o_m_nxt + o_h_nxt;
            bias_ipsum_sel       <= (c_nxt == '0);
        end
    end

    assign pass_start = (state == LAUNCH);
    assign busy       = (state != IDLE);
    assign layer_done = (state == DONE);
endmodule
